// File: rtl/data_mem_pkg.sv
// Shared definitions for the CPU data-port to SRAM-bus bridge: access size codes,
// bridge FSM states and request legality helpers.
package data_mem_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Bits needed for a counter that reaches TIMEOUT-1.
  function automatic int unsigned timer_width(input int unsigned limit);
    return (limit < 32'd2) ? 32'd1 : $clog2(limit + 32'd1);
  endfunction

  // Unsigned variants exist only for loads.
  function automatic logic size_legal(input logic we, input logic [2:0] size);
    logic ok;
    case (size)
      SZ_B, SZ_H, SZ_W: ok = 1'b1;
      SZ_BU, SZ_HU:     ok = ~we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic size_aligned(input logic [2:0] size, input logic [1:0] off);
    logic ok;
    case (size)
      SZ_H, SZ_HU: ok = (off[0] == 1'b0);
      SZ_W:        ok = (off == 2'b00);
      default:     ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load data path: picks the addressed byte/half from the bus word and sign- or
// zero-extends it according to the access size.
module mem_load_ext
  import data_mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  size_i,
  output logic [31:0] data_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = 8'h00;
    case (off_i)
      2'd0:    lane_b = rdata_i[7:0];
      2'd1:    lane_b = rdata_i[15:8];
      2'd2:    lane_b = rdata_i[23:16];
      default: lane_b = rdata_i[31:24];
    endcase
  end

  assign lane_h = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    data_o = rdata_i;
    case (size_i)
      SZ_B:    data_o = {{24{lane_b[7]}}, lane_b};
      SZ_BU:   data_o = {24'h000000, lane_b};
      SZ_H:    data_o = {{16{lane_h[15]}}, lane_h};
      SZ_HU:   data_o = {16'h0000, lane_h};
      SZ_W:    data_o = rdata_i;
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/data_mem_bridge.sv
// Bridge between the single-cycle CPU data port and a handshaked, variable-latency
// SRAM bus: stalls the CPU, aligns stores, extends loads, flags bad accesses/timeouts.
module data_mem_bridge
  import data_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [2:0]            cpu_size,
  input  logic [DATA_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  output logic                  cpu_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned   TW   = timer_width(TIMEOUT);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 32'd1);

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [31:0]   addr_q, addr_d;
  logic          we_q, we_d;
  logic [2:0]    size_q, size_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic          mem_req_q, mem_req_d;
  logic          err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;

  logic          req_ok;
  logic [3:0]    st_strb;
  logic [31:0]   st_data;
  logic [31:0]   ld_data;

  assign req_ok = size_legal(cpu_we, cpu_size) & size_aligned(cpu_size, cpu_addr[1:0]);

  // Store lane replication and byte strobes, computed from the live CPU request.
  always_comb begin
    st_strb = 4'b0000;
    st_data = cpu_wdata;
    if (cpu_we) begin
      case (cpu_size)
        SZ_B: begin
          st_strb = 4'b0001 << cpu_addr[1:0];
          st_data = {4{cpu_wdata[7:0]}};
        end
        SZ_H: begin
          st_strb = 4'b0011 << cpu_addr[1:0];
          st_data = {2{cpu_wdata[15:0]}};
        end
        SZ_W:    st_strb = 4'b1111;
        default: st_strb = 4'b0000;
      endcase
    end else begin
      st_strb = 4'b0000;
    end
  end

  mem_load_ext u_load_ext (
    .rdata_i (mem_rdata),
    .off_i   (addr_q[1:0]),
    .size_i  (size_q),
    .data_o  (ld_data)
  );

  // Next-state logic; a real response takes priority over a timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    addr_d  = addr_q;
    we_d    = we_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req && req_ok) begin
          state_d = ST_ISSUE;
          timer_d = '0;
          addr_d  = cpu_addr;
          we_d    = cpu_we;
          size_d  = cpu_size;
          wdata_d = st_data;
          wstrb_d = st_strb;
        end else if (cpu_req) begin
          err_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE, ST_WAIT: begin
        timer_d = timer_q + 1'b1;
        if (mem_rvalid && (mem_gnt || state_q == ST_WAIT)) begin
          state_d = ST_DONE;
          rdata_d = we_q ? rdata_q : ld_data;
        end else if (timer_q == TMAX) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
          rdata_d = 32'h0000_0000;
        end else if (mem_gnt) begin
          state_d = ST_WAIT;
        end else begin
          state_d = state_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase
    mem_req_d = (state_d == ST_ISSUE);
  end

  // State and captured-request registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      addr_q    <= 32'h0000_0000;
      we_q      <= 1'b0;
      size_q    <= 3'b000;
      wdata_q   <= 32'h0000_0000;
      wstrb_q   <= 4'b0000;
      mem_req_q <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= 32'h0000_0000;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      size_q    <= size_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      mem_req_q <= mem_req_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign cpu_stall = (state_q == ST_IDLE && cpu_req && req_ok) ||
                     (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign cpu_err   = err_q;
  assign cpu_rdata = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = we_q;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;

endmodule
